// File: rtl/utx_pkg.sv
// Shared definitions for the parametrised UART transmitter (utx_param).
// State encoding and the bit-counter width helper.
package utx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } utx_state_e;

  // Width needed to count 0..data_bits.
  function automatic int utx_cnt_width(input int data_bits);
    return $clog2(data_bits + 1);
  endfunction

endpackage

// File: rtl/utx_param_if.sv
// Input handshake bundle for utx_param: valid/ready word transfer plus the
// per-frame settings latched on accept. parity_odd exists only when
// UTX_PARITY_EN is defined.
interface utx_param_if #(
  parameter int DATA_BITS = 8,
  parameter int DIV_WIDTH = 11
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_BITS-1:0] in_data;
  logic [DIV_WIDTH-1:0] baud_div;
`ifdef UTX_PARITY_EN
  logic                 parity_odd;

  modport master (output in_valid, in_data, baud_div, parity_odd, input in_ready);
  modport slave  (input in_valid, in_data, baud_div, parity_odd, output in_ready);
`else
  modport master (output in_valid, in_data, baud_div, input in_ready);
  modport slave  (input in_valid, in_data, baud_div, output in_ready);
`endif
endinterface

// File: rtl/utx_baudgen.sv
// Bit-period timer for utx_param: tick is high on the last clock of each
// bit period (div+1 clocks long); restart forces the period to begin anew.
module utx_baudgen #(
  parameter int DIV_WIDTH = 11
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 restart,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt;

  assign tick = (cnt == div);

  // Count clocks within a bit period, wrapping at the divisor or on restart.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/utx_param.sv
// Parametrised UART transmitter: DATA_BITS data bits (LSB first), STOP_BITS
// stop bits, runtime baud divisor, valid/ready input allowing gapless frames.
// Optional parity bit enabled by the UTX_PARITY_EN macro.
module utx_param
  import utx_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int DIV_WIDTH = 11
) (
  input  logic       clk,
  input  logic       rstn,
  utx_param_if.slave bus,
  output logic       serialout,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = utx_cnt_width(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  utx_state_e           state, state_n;
  logic [CNT_W-1:0]     bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [DIV_WIDTH-1:0] div_q;
  logic                 line_n;
  logic                 up;
  logic                 tick;
  logic                 accept;
  logic                 last_stop;
`ifdef UTX_PARITY_EN
  logic                 par_q;
`endif

  utx_baudgen #(.DIV_WIDTH(DIV_WIDTH)) u_baudgen (
    .clk     (clk),
    .rstn    (rstn),
    .restart (accept),
    .div     (div_q),
    .tick    (tick)
  );

  // up keeps in_ready low while reset is asserted and until the first clock after release.
  assign last_stop    = (state == STOP) && tick && (bit_cnt == LAST_STOP);
  assign bus.in_ready = up && ((state == IDLE) || last_stop);
  assign accept       = bus.in_valid && bus.in_ready;
  assign busy         = (state != IDLE);

  // Next state, next line level, shift and bit counter.
  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    shift_n = shift;
    line_n  = serialout;
    case (state)
      IDLE: line_n = 1'b1;
      START: begin
        if (tick) begin
          state_n = DATA;
          line_n  = shift[0];
          bit_n   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt == LAST_DATA) begin
            bit_n   = '0;
`ifdef UTX_PARITY_EN
            state_n = PARITY;
            line_n  = par_q;
`else
            state_n = STOP;
            line_n  = 1'b1;
`endif
          end else begin
            bit_n   = bit_cnt + 1'b1;
            shift_n = shift >> 1;
            line_n  = shift[1];
          end
        end
      end
`ifdef UTX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_n = STOP;
          line_n  = 1'b1;
          bit_n   = '0;
        end
      end
`endif
      STOP: begin
        line_n = 1'b1;
        if (tick) begin
          if (bit_cnt == LAST_STOP) begin
            state_n = IDLE;
            bit_n   = '0;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        line_n  = 1'b1;
        bit_n   = '0;
      end
    endcase
    // Accept only happens in IDLE or the final stop cycle; it always starts a frame.
    if (accept) begin
      state_n = START;
      line_n  = 1'b0;
      shift_n = bus.in_data;
      bit_n   = '0;
    end
  end

  // Control registers: state, counters, serial line, done pulse, ready enable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      serialout <= 1'b1;
      done      <= 1'b0;
      up        <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_n;
      serialout <= line_n;
      done      <= last_stop;
      up        <= 1'b1;
    end
  end

  // Data registers: shift register and per-frame settings latched on accept.
  always_ff @(posedge clk) begin
    shift <= shift_n;
    if (accept) begin
      div_q <= bus.baud_div;
`ifdef UTX_PARITY_EN
      par_q <= (^bus.in_data) ^ bus.parity_odd;
`endif
    end
  end

endmodule

// File: tb/tb_utx_param.sv
// Bench for utx_param: an 8N1 instance and a 7-data/2-stop instance, driven
// one at a time. Expected serial waveforms come from a frame-level model.
// Build with UTX_PARITY_EN defined to exercise the parity bit.
module tb_utx_param;

`ifdef UTX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        tb_valid = 1'b0;
  logic [8:0]  tb_data = '0;
  logic [10:0] tb_div = '0;
  logic        tb_odd = 1'b0;

  int checks = 0;
  int errors = 0;

  int         exp_q[$];
  logic [8:0] seq_data[4];
  int         seq_div[4];
  logic       seq_odd[4];

  utx_param_if #(.DATA_BITS(8), .DIV_WIDTH(11)) bus_a ();
  utx_param_if #(.DATA_BITS(7), .DIV_WIDTH(11)) bus_b ();

  assign bus_a.in_valid = tb_valid & ~sel;
  assign bus_a.in_data  = tb_data[7:0];
  assign bus_a.baud_div = tb_div;
  assign bus_b.in_valid = tb_valid & sel;
  assign bus_b.in_data  = tb_data[6:0];
  assign bus_b.baud_div = tb_div;
`ifdef UTX_PARITY_EN
  assign bus_a.parity_odd = tb_odd;
  assign bus_b.parity_odd = tb_odd;
`endif

  logic line_a, busy_a, done_a;
  logic line_b, busy_b, done_b;

  utx_param #(.DATA_BITS(8), .STOP_BITS(1), .DIV_WIDTH(11)) dut_a (
    .clk(clk), .rstn(rstn), .bus(bus_a),
    .serialout(line_a), .busy(busy_a), .done(done_a));

  utx_param #(.DATA_BITS(7), .STOP_BITS(2), .DIV_WIDTH(11)) dut_b (
    .clk(clk), .rstn(rstn), .bus(bus_b),
    .serialout(line_b), .busy(busy_b), .done(done_b));

  logic obs_line, obs_busy, obs_done, obs_ready;
  assign obs_line  = sel ? line_b : line_a;
  assign obs_busy  = sel ? busy_b : busy_a;
  assign obs_done  = sel ? done_b : done_a;
  assign obs_ready = sel ? bus_b.in_ready : bus_a.in_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Frame model: start, data LSB first, optional parity, stop bits, each div+1 clocks.
  function automatic int build(input logic [8:0] d, input int div, input logic odd,
                               input int db, input int sb);
    int   bits[$];
    logic p;
    p = odd;
    bits.push_back(0);
    for (int i = 0; i < db; i++) begin
      bits.push_back(int'(d[i]));
      p = p ^ d[i];
    end
    if (PAR == 1) bits.push_back(int'(p));
    for (int i = 0; i < sb; i++) bits.push_back(1);
    foreach (bits[k]) repeat (div + 1) exp_q.push_back(bits[k]);
    return bits.size() * (div + 1);
  endfunction

  task automatic present(input int k);
    tb_data  = seq_data[k];
    tb_div   = 11'(seq_div[k]);
    tb_odd   = seq_odd[k];
    tb_valid = 1'b1;
  endtask

  task automatic scramble();
    tb_data = 9'($urandom);
    tb_div  = 11'($urandom);
    tb_odd  = 1'($urandom);
  endtask

  // Send n words back to back with in_valid held, checking every clock.
  task automatic run_seq(input int n);
    int db, sb, total, cur, g;
    int ends[4];
    int dexp, rexp;
    db = sel ? 7 : 8;
    sb = sel ? 2 : 1;
    exp_q.delete();
    total = 0;
    for (int i = 0; i < n; i++) begin
      total += build(seq_data[i], seq_div[i], seq_odd[i], db, sb);
      ends[i] = total - 1;
    end
    g = 0;
    while (!obs_ready && g < 500) begin
      @(posedge clk); #1;
      g++;
    end
    check("idle_ready", 32'(obs_ready), 32'd1);
    present(0);
    @(posedge clk); #1;
    cur = 0;
    if (n > 1) present(1);
    else begin
      tb_valid = 1'b0;
      scramble();
    end
    for (int t = 0; t < total; t++) begin
      dexp = 0;
      rexp = 0;
      for (int i = 0; i < n; i++) begin
        if (ends[i] + 1 == t) dexp = 1;
        if (ends[i] == t) rexp = 1;
      end
      check("line", 32'(obs_line), exp_q[t]);
      check("busy", 32'(obs_busy), 32'd1);
      check("done", 32'(obs_done), dexp);
      check("ready", 32'(obs_ready), rexp);
      @(posedge clk); #1;
      if (t == ends[cur] && cur < n - 1) begin
        cur++;
        if (cur + 1 < n) present(cur + 1);
        else begin
          tb_valid = 1'b0;
          scramble();
        end
      end else if (!tb_valid) begin
        scramble();
      end
    end
    check("end_line", 32'(obs_line), 32'd1);
    check("end_busy", 32'(obs_busy), 32'd0);
    check("end_done", 32'(obs_done), 32'd1);
    check("end_ready", 32'(obs_ready), 32'd1);
    @(posedge clk); #1;
    check("post_done", 32'(obs_done), 32'd0);
    check("post_line", 32'(obs_line), 32'd1);
  endtask

  initial begin
    // Reset state of both instances.
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      check("rst_line", 32'(obs_line), 32'd1);
      check("rst_busy", 32'(obs_busy), 32'd0);
      check("rst_done", 32'(obs_done), 32'd0);
      check("rst_ready", 32'(obs_ready), 32'd0);
    end
    sel = 1'b0;
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    check("rel_ready", 32'(obs_ready), 32'd1);

    // 8N1, 0xA5, 4 clocks per bit.
    seq_data[0] = 9'h0A5; seq_div[0] = 3; seq_odd[0] = 1'b0;
    run_seq(1);

    // Gapless 0x55 then 0xAA at one clock per bit.
    seq_data[0] = 9'h055; seq_div[0] = 0; seq_odd[0] = 1'b0;
    seq_data[1] = 9'h0AA; seq_div[1] = 0; seq_odd[1] = 1'b0;
    run_seq(2);

    // 7 data bits, 2 stop bits.
    sel = 1'b1;
    seq_data[0] = 9'h07F; seq_div[0] = 1; seq_odd[0] = 1'b0;
    run_seq(1);
    sel = 1'b0;

    // Even then odd parity on 0xA5.
    seq_data[0] = 9'h0A5; seq_div[0] = 1; seq_odd[0] = 1'b0;
    seq_data[1] = 9'h0A5; seq_div[1] = 1; seq_odd[1] = 1'b1;
    run_seq(2);

    // Divisor changes to 9 while a 4-clock-bit frame is in flight.
    seq_data[0] = 9'h03C; seq_div[0] = 3; seq_odd[0] = 1'b1;
    seq_data[1] = 9'h0C3; seq_div[1] = 9; seq_odd[1] = 1'b0;
    run_seq(2);

    // Reset asserted during DATA.
    seq_data[0] = 9'h0F3; seq_div[0] = 2; seq_odd[0] = 1'b0;
    present(0);
    @(posedge clk); #1;
    tb_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("mid_busy", 32'(obs_busy), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("arst_line", 32'(obs_line), 32'd1);
    check("arst_busy", 32'(obs_busy), 32'd0);
    check("arst_ready", 32'(obs_ready), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("arst_done", 32'(obs_done), 32'd0);
    end
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    check("arel_ready", 32'(obs_ready), 32'd1);
    check("arel_done", 32'(obs_done), 32'd0);
    seq_data[0] = 9'h0F3; seq_div[0] = 2; seq_odd[0] = 1'b1;
    run_seq(1);

    // Randomized sequences on both instances.
    for (int r = 0; r < 25; r++) begin
      int n;
      n = $urandom_range(1, 3);
      sel = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        seq_data[i] = 9'($urandom);
        seq_div[i]  = $urandom_range(0, 4);
        seq_odd[i]  = 1'($urandom);
      end
      run_seq(n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
